// File: rtl/ct_spsram_pkg.sv
// ---------------------------------------------------------------------------
// ct_spsram_pkg
// Shared types and helpers for the taint-tracking single-port SRAM.
//   state_e    : controller state (post-reset sweep or normal operation)
//   ctl_taint(): combines the control-path taint sources into one bit
// ---------------------------------------------------------------------------
package ct_spsram_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_e;

  // Any taint on address, chip enable or write enable makes the accessed
  // row (and therefore the whole access) untrustworthy.
  function automatic logic ctl_taint(input logic a_taint_any,
                                     input logic cen_taint,
                                     input logic gwen_taint);
    return a_taint_any | cen_taint | gwen_taint;
  endfunction

endpackage

// File: rtl/ct_spsram_taint_array.sv
// ---------------------------------------------------------------------------
// ct_spsram_taint_array
// DEPTH x DATA_WIDTH register array with one write port (per-bit enable)
// and one asynchronous read port. Used for both the data store and the
// shadow taint store. Contents are not reset; the owner sweeps them.
// Ports:
//   clk    in  1           clock
//   we     in  1           write enable (active high)
//   waddr  in  ADDR_WIDTH  write row (caller guarantees < DEPTH)
//   wmask  in  DATA_WIDTH  per-bit write enable (active high)
//   wdata  in  DATA_WIDTH  write data
//   raddr  in  ADDR_WIDTH  read row
//   rdata  out DATA_WIDTH  row contents at raddr
// ---------------------------------------------------------------------------
module ct_spsram_taint_array #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 59,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wmask,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Only the bits selected by wmask change; the rest of the row is kept.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= (mem[waddr] & ~wmask) | (wdata & wmask);
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ct_spsram_taint_gen.sv
// ---------------------------------------------------------------------------
// ct_spsram_taint_gen
// Parametrised single-port SRAM with bit-write mask and a shadow taint
// array. After reset both arrays are cleared by a sweep, one row per cycle.
// Ports:
//   CLK, RST              clock, synchronous active-high reset
//   CEN, GWEN             chip enable / global write enable, active low
//   A, D, WEN             address, write data, per-bit write enable (low)
//   Q                     read data
//   CEN_t0 .. WEN_t0      taint of the matching input
//   Q_t0                  taint of Q
//   INIT_BUSY             clearing sweep in progress, accesses ignored
// ---------------------------------------------------------------------------
module ct_spsram_taint_gen
  import ct_spsram_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 59,
  parameter int DEPTH      = 2 ** ADDR_WIDTH,
  parameter int OUT_REG    = 0,
  parameter int TAINT_EN   = 1,
  parameter int INIT_EN    = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CEN,
  input  logic                  GWEN,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic [DATA_WIDTH-1:0] WEN,
  output logic [DATA_WIDTH-1:0] Q,
  input  logic                  CEN_t0,
  input  logic                  GWEN_t0,
  input  logic [ADDR_WIDTH-1:0] A_t0,
  input  logic [DATA_WIDTH-1:0] D_t0,
  input  logic [DATA_WIDTH-1:0] WEN_t0,
  output logic [DATA_WIDTH-1:0] Q_t0,
  output logic                  INIT_BUSY
);

  // One extra counter bit so a full 2**ADDR_WIDTH sweep ends without wrapping.
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_C  = CW'(DEPTH - 1);

  state_e                state;
  logic [CW-1:0]         cnt;
  logic                  sweep;
  logic                  idle;
  logic                  in_range;
  logic                  ctl_t;
  logic                  rd_fire;
  logic                  data_we;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] data_mask;
  logic [DATA_WIDTH-1:0] data_wdata;
  logic [DATA_WIDTH-1:0] data_rd;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] rd_taint;
  logic [DATA_WIDTH-1:0] q_r;
  logic [DATA_WIDTH-1:0] qt_r;

  // Controller: reset restarts the sweep from row 0 in any state; the sweep
  // visits rows 0..DEPTH-1 and then hands over to normal operation.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= (INIT_EN != 0) ? ST_INIT : ST_IDLE;
      cnt   <= '0;
    end else if (state == ST_INIT) begin
      if (cnt == LAST_C) begin
        state <= ST_IDLE;
      end
      cnt <= cnt + 1'b1;
    end
  end

  assign sweep     = (state == ST_INIT);
  assign idle      = (state == ST_IDLE);
  assign INIT_BUSY = sweep;
  assign in_range  = ({1'b0, A} < DEPTH_C);
  assign ctl_t     = ctl_taint(|A_t0, CEN_t0, GWEN_t0);

  // Reads of rows beyond DEPTH return zero rather than array garbage.
  assign rd_fire = idle & ~CEN & GWEN;
  assign rd_data = in_range ? data_rd : '0;

  // During the sweep the write port is stolen to zero row cnt.
  assign data_we    = sweep | (idle & ~CEN & ~GWEN & in_range);
  assign wr_addr    = sweep ? cnt[ADDR_WIDTH-1:0] : A;
  assign data_mask  = sweep ? '1 : ~WEN;
  assign data_wdata = sweep ? '0 : D;

  ct_spsram_taint_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_data (
    .clk   (CLK),
    .we    (data_we),
    .waddr (wr_addr),
    .wmask (data_mask),
    .wdata (data_wdata),
    .raddr (A),
    .rdata (data_rd)
  );

  generate
    if (TAINT_EN != 0) begin : g_taint
      logic                  wcap;
      logic                  sticky;
      logic                  sh_we;
      logic [DATA_WIDTH-1:0] sh_mask;
      logic [DATA_WIDTH-1:0] sh_wdata;
      logic [DATA_WIDTH-1:0] sh_rd;

      // A cycle "could have written" if a tainted enable might have been active.
      assign wcap = idle & (~CEN | CEN_t0) & (~GWEN | GWEN_t0);

      // Tainted mask bit or tainted control forces the shadow bit to 1;
      // otherwise a clean write simply copies D_t0 into the shadow.
      assign sh_we    = sweep | (wcap & in_range);
      assign sh_mask  = sweep ? '1 : (~WEN | WEN_t0);
      assign sh_wdata = sweep ? '0 : (D_t0 | WEN_t0 | {DATA_WIDTH{ctl_t}});

      ct_spsram_taint_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
      ) u_shadow (
        .clk   (CLK),
        .we    (sh_we),
        .waddr (wr_addr),
        .wmask (sh_mask),
        .wdata (sh_wdata),
        .raddr (A),
        .rdata (sh_rd)
      );

      // A possible write to an unknown row could have hit any row, so from
      // then on every read is treated as fully tainted until reset.
      always_ff @(posedge CLK) begin
        if (RST) begin
          sticky <= 1'b0;
        end else if (wcap & (|A_t0)) begin
          sticky <= 1'b1;
        end
      end

      assign rd_taint = (in_range ? sh_rd : '0) | {DATA_WIDTH{ctl_t | sticky}};
    end else begin : g_no_taint
      assign rd_taint = '0;
    end
  endgenerate

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic                  s1_v;
      logic [DATA_WIDTH-1:0] s1_q;
      logic [DATA_WIDTH-1:0] s1_t;

      // Two-stage read: Q only moves when a read reaches the last stage, so
      // it holds through idle and write cycles. Reset drops in-flight reads.
      always_ff @(posedge CLK) begin
        if (RST) begin
          s1_v <= 1'b0;
          s1_q <= '0;
          s1_t <= '0;
          q_r  <= '0;
          qt_r <= '0;
        end else begin
          s1_v <= rd_fire;
          if (rd_fire) begin
            s1_q <= rd_data;
            s1_t <= rd_taint;
          end
          if (s1_v) begin
            q_r  <= s1_q;
            qt_r <= s1_t;
          end
        end
      end
    end else begin : g_noreg
      // Single-stage read; Q holds whenever no read happens.
      always_ff @(posedge CLK) begin
        if (RST) begin
          q_r  <= '0;
          qt_r <= '0;
        end else if (rd_fire) begin
          q_r  <= rd_data;
          qt_r <= rd_taint;
        end
      end
    end
  endgenerate

  assign Q    = q_r;
  assign Q_t0 = qt_r;

endmodule

// File: tb/tb_ct_spsram_taint_gen.sv
// ---------------------------------------------------------------------------
// tb_ct_spsram_taint_gen
// Drives two builds of the SRAM with the same inputs: the default build
// (OUT_REG=0, TAINT_EN=1) and a reduced build (OUT_REG=1, TAINT_EN=0).
// A behavioural model tracks the expected contents, taint and outputs of
// both; a negedge process compares them every cycle, and the directed
// sequence adds literal expectations for the scenarios of interest.
// ---------------------------------------------------------------------------
module tb_ct_spsram_taint_gen;

  localparam int AW    = 9;
  localparam int DW    = 59;
  localparam int DEPTH = 512;
  localparam logic [DW-1:0] ALL1 = '1;

  logic          clk;
  logic          rst;
  logic          cen;
  logic          gwen;
  logic [AW-1:0] a;
  logic [DW-1:0] d;
  logic [DW-1:0] wen;
  logic          cen_t;
  logic          gwen_t;
  logic [AW-1:0] a_t;
  logic [DW-1:0] d_t;
  logic [DW-1:0] wen_t;

  logic [DW-1:0] q1;
  logic [DW-1:0] qt1;
  logic          busy1;
  logic [DW-1:0] q2;
  logic [DW-1:0] qt2;
  logic          busy2;

  int checkCount = 0;
  int passCount  = 0;
  bit checking   = 0;

  ct_spsram_taint_gen #(
    .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .DEPTH (DEPTH),
    .OUT_REG (0), .TAINT_EN (1), .INIT_EN (1)
  ) dut (
    .CLK (clk), .RST (rst), .CEN (cen), .GWEN (gwen), .A (a), .D (d), .WEN (wen),
    .Q (q1), .CEN_t0 (cen_t), .GWEN_t0 (gwen_t), .A_t0 (a_t), .D_t0 (d_t),
    .WEN_t0 (wen_t), .Q_t0 (qt1), .INIT_BUSY (busy1)
  );

  ct_spsram_taint_gen #(
    .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .DEPTH (DEPTH),
    .OUT_REG (1), .TAINT_EN (0), .INIT_EN (1)
  ) dut_lite (
    .CLK (clk), .RST (rst), .CEN (cen), .GWEN (gwen), .A (a), .D (d), .WEN (wen),
    .Q (q2), .CEN_t0 (cen_t), .GWEN_t0 (gwen_t), .A_t0 (a_t), .D_t0 (d_t),
    .WEN_t0 (wen_t), .Q_t0 (qt2), .INIT_BUSY (busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state
  logic [DW-1:0] memM [DEPTH];
  logic [DW-1:0] shM  [DEPTH];
  int            remM = 0;
  bit            stickyM = 0;
  logic [DW-1:0] qM = '0;
  logic [DW-1:0] qtM = '0;
  logic [DW-1:0] q2M = '0;
  bit            pendV = 0;
  logic [DW-1:0] pendQ = '0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: reset arms a DEPTH-cycle busy window; afterwards each cycle is
  // an access evaluated straight from the behaviour rules.
  always @(posedge clk) begin
    if (rst) begin
      remM    = DEPTH;
      stickyM = 0;
      qM      = '0;
      qtM     = '0;
      q2M     = '0;
      pendV   = 0;
      pendQ   = '0;
      for (int r = 0; r < DEPTH; r++) begin
        memM[r] = '0;
        shM[r]  = '0;
      end
    end else if (remM > 0) begin
      remM = remM - 1;
    end else begin
      logic ctl;
      ctl = (|a_t) | cen_t | gwen_t;
      if (pendV) q2M = pendQ;
      pendV = 0;
      if (!cen && gwen) begin
        qM    = memM[a];
        qtM   = shM[a] | ((ctl || stickyM) ? ALL1 : '0);
        pendV = 1;
        pendQ = memM[a];
      end
      if (!cen && !gwen) begin
        memM[a] = (memM[a] & wen) | (d & ~wen);
      end
      if ((!cen || cen_t) && (!gwen || gwen_t)) begin
        if (|a_t) stickyM = 1;
        for (int i = 0; i < DW; i++) begin
          if (!wen[i] || wen_t[i]) shM[a][i] = (wen_t[i] || ctl) ? 1'b1 : d_t[i];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      checkOutput("m_q",     q1,    qM);
      checkOutput("m_qt",    qt1,   qtM);
      checkOutput("m_busy",  busy1, remM > 0);
      checkOutput("m_q2",    q2,    q2M);
      checkOutput("m_qt2",   qt2,   0);
      checkOutput("m_busy2", busy2, remM > 0);
    end
  end

  task automatic applyStimulus(input logic c, input logic g, input logic [AW-1:0] addr,
                               input logic [DW-1:0] data, input logic [DW-1:0] mask,
                               input logic [AW-1:0] addrT, input logic [DW-1:0] dataT,
                               input logic [DW-1:0] maskT);
    cen = c; gwen = g; a = addr; d = data; wen = mask;
    cen_t = 1'b0; gwen_t = 1'b0; a_t = addrT; d_t = dataT; wen_t = maskT;
    @(negedge clk);
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b1, 1'b1, '0, '0, '1, '0, '0, '0);
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    idleCycles(1);
    rst = 1'b0;
  endtask

  task automatic waitSweep(input string name);
    int n;
    n = 0;
    while (busy1 === 1'b1 && n < 1000) begin
      n++;
      idleCycles(1);
    end
    checkOutput(name, n, DEPTH);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0;
    cen = 1'b1; gwen = 1'b1; a = '0; d = '0; wen = '1;
    cen_t = 1'b0; gwen_t = 1'b0; a_t = '0; d_t = '0; wen_t = '0;
    @(negedge clk);

    // Reset and clearing sweep
    pulseReset();
    checking = 1;
    checkOutput("rst_busy", busy1, 1);
    checkOutput("rst_q", q1, 0);
    checkOutput("rst_qt", qt1, 0);
    waitSweep("sweep_len");
    applyStimulus(1'b0, 1'b1, 9'd100, '0, '1, '0, '0, '0);
    checkOutput("s1_q", q1, 0);
    checkOutput("s1_qt", qt1, 0);

    // Full write then read, plus latency-2 build
    applyStimulus(1'b0, 1'b0, 9'd5, 59'h155, '0, '0, '0, '0);
    applyStimulus(1'b0, 1'b1, 9'd5, '0, '1, '0, '0, '0);
    checkOutput("s2_q", q1, 59'h155);
    checkOutput("s2_q2_lat1", q2, 0);
    idleCycles(1);
    checkOutput("s2_q2_lat2", q2, 59'h155);
    idleCycles(3);
    checkOutput("s2_q_hold", q1, 59'h155);
    applyStimulus(1'b0, 1'b0, 9'd6, 59'h2AA, '0, '0, '0, '0);
    checkOutput("s2_q_hold_wr", q1, 59'h155);

    // Masked write: bit 0 protected
    applyStimulus(1'b0, 1'b0, 9'd7, ALL1, 59'h1, '0, '0, '0);
    applyStimulus(1'b0, 1'b1, 9'd7, '0, '1, '0, '0, '0);
    checkOutput("s3_q", q1, 59'h7FF_FFFF_FFFF_FFFE);

    // Data taint stored, overwritten, and control taint on read
    applyStimulus(1'b0, 1'b0, 9'd3, 59'h3C, '0, '0, 59'h1, '0);
    applyStimulus(1'b0, 1'b1, 9'd3, '0, '1, '0, '0, '0);
    checkOutput("s4_qt_set", qt1, 59'h1);
    checkOutput("s4_q", q1, 59'h3C);
    applyStimulus(1'b0, 1'b0, 9'd3, 59'h3C, '0, '0, '0, '0);
    applyStimulus(1'b0, 1'b1, 9'd3, '0, '1, '0, '0, '0);
    checkOutput("s4_qt_clr", qt1, 0);
    applyStimulus(1'b0, 1'b1, 9'd3, '0, '1, 9'h1, '0, '0);
    checkOutput("s4_qt_ctl", qt1, ALL1);
    checkOutput("s4_q_ctl", q1, 59'h3C);
    idleCycles(1);
    checkOutput("s6_qt2_zero", qt2, 0);

    // Tainted mask bit on an otherwise masked-off write
    applyStimulus(1'b0, 1'b0, 9'd4, 59'h7F, '1, '0, '0, 59'h10);
    applyStimulus(1'b0, 1'b1, 9'd4, '0, '1, '0, '0, '0);
    checkOutput("s4_qt_wen", qt1, 59'h10);
    checkOutput("s4_q_wen", q1, 0);

    // Sticky after address-tainted write
    applyStimulus(1'b0, 1'b0, 9'd9, '0, '0, 9'h1, '0, '0);
    applyStimulus(1'b0, 1'b1, 9'd5, '0, '1, '0, '0, '0);
    checkOutput("s5_sticky_qt", qt1, ALL1);
    checkOutput("s5_sticky_q", q1, 59'h155);
    idleCycles(2);
    applyStimulus(1'b0, 1'b1, 9'd6, '0, '1, '0, '0, '0);
    checkOutput("s5_sticky_qt2", qt1, ALL1);

    // Reset mid-sweep restarts the full sweep and clears everything
    pulseReset();
    idleCycles(99);
    checkOutput("s5_busy_mid", busy1, 1);
    pulseReset();
    checkOutput("s5_rst_q", q1, 0);
    waitSweep("s5_sweep_len");
    applyStimulus(1'b0, 1'b1, 9'd5, '0, '1, '0, '0, '0);
    checkOutput("s5_after_q", q1, 0);
    checkOutput("s5_after_qt", qt1, 0);
    idleCycles(3);

    checking = 0;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
